// File: rtl/psk_pkg.sv
// Shared types and constants for the PSK loopback bit-error-rate checker.
package psk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StLocked
    } state_e;

    localparam logic [1:0] RotStep     = 2'd1;
    localparam logic [1:0] RotLastBpsk = 2'd1;
    localparam logic [1:0] RotLastQpsk = 2'd3;

    // QPSK constellation in rotation order: 00 -> 01 -> 11 -> 10 -> 00.
    localparam logic [3:0][1:0] GraySeq = {2'b10, 2'b11, 2'b01, 2'b00};

    // Position of a symbol within GraySeq.
    function automatic logic [1:0] gray_index(logic [1:0] sym);
        return {sym[1], sym[1] ^ sym[0]};
    endfunction

endpackage

// File: rtl/psk_sym_rotate.sv
// Combinational phase rotation of a BPSK/QPSK symbol by a number of constellation steps.
module psk_sym_rotate
    import psk_pkg::*;
(
    input  logic [1:0] sym,
    input  logic [1:0] rot,
    input  logic       is_bpsk,
    output logic [1:0] rot_sym
);

    logic [1:0] idx;

    always_comb begin
        idx = gray_index(sym) + rot;
        if (is_bpsk) begin
            // Only bit0 carries BPSK data; bit1 passes through untouched.
            rot_sym = {sym[1], sym[0] ^ rot[0]};
        end else begin
            rot_sym = GraySeq[idx];
        end
    end

endmodule

// File: rtl/psk_loopback_ber.sv
// Loopback BER checker: searches Tx history delay and phase rotation for lock,
// then counts received symbols and bit errors while locked.
module psk_loopback_ber
    import psk_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned WIN      = 64,
    parameter int unsigned LOCK_THR = 2,
    parameter int unsigned LOSS_THR = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                     clk_16M384,
    input  logic                     rst_n_16M384,
    input  logic                     enable,
    input  logic                     is_bpsk,
    input  logic                     clear,
    input  logic [1:0]               tx_bits,
    input  logic                     tx_vld,
    input  logic [1:0]               rx_bits,
    input  logic                     rx_vld,
    output logic                     locked,
    output logic [$clog2(DEPTH)-1:0] delay,
    output logic [1:0]               rot,
    output logic [CNT_W-1:0]         sym_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     err_pulse
);

    localparam int unsigned DelayW = $clog2(DEPTH);
    localparam int unsigned WinW   = $clog2(WIN + 1);

    state_e                 state_q, state_d;
    logic [DEPTH-1:0][1:0]  hist_q, hist_d;
    logic [DelayW-1:0]      delay_q, delay_d;
    logic [1:0]             rot_q, rot_d;
    logic [WinW-1:0]        win_q, win_d, mis_q, mis_d;
    logic [CNT_W-1:0]       sym_q, sym_d, err_q, err_d;
    logic                   err_pulse_q, err_pulse_d;
    logic                   locked_q, bpsk_q;

    logic [1:0]             ref_sym, diff, bit_errs, rot_last;
    logic                   mismatch, win_done;
    logic [WinW-1:0]        mis_total;
    logic [CNT_W:0]         sym_sum, err_sum;

    psk_sym_rotate u_rotate (
        .sym     (hist_q[delay_q]),
        .rot     (rot_q),
        .is_bpsk (is_bpsk),
        .rot_sym (ref_sym)
    );

    always_comb begin
        diff      = rx_bits ^ ref_sym;
        bit_errs  = is_bpsk ? {1'b0, diff[0]} : {diff[1] & diff[0], diff[1] ^ diff[0]};
        mismatch  = |bit_errs;
        mis_total = mis_q + WinW'(mismatch);
        win_done  = rx_vld && (win_q == WinW'(WIN - 1));
        sym_sum   = {1'b0, sym_q} + {{CNT_W{1'b0}}, 1'b1};
        err_sum   = {1'b0, err_q} + {{(CNT_W - 1){1'b0}}, bit_errs};
        hist_d    = hist_q;
        if (tx_vld) begin
            hist_d = {hist_q[DEPTH-2:0], tx_bits};
        end
    end

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        rot_d       = rot_q;
        win_d       = win_q;
        mis_d       = mis_q;
        sym_d       = sym_q;
        err_d       = err_q;
        err_pulse_d = 1'b0;
        rot_last    = is_bpsk ? RotLastBpsk : RotLastQpsk;

        unique case (state_q)
            StIdle: begin
                win_d = '0;
                mis_d = '0;
                if (enable) begin
                    state_d = StSearch;
                    delay_d = '0;
                    rot_d   = '0;
                end
            end
            StSearch: begin
                if (rx_vld) begin
                    win_d = win_q + WinW'(1);
                    mis_d = mis_total;
                end
                if (win_done) begin
                    win_d = '0;
                    mis_d = '0;
                    if (mis_total <= WinW'(LOCK_THR)) begin
                        state_d = StLocked;
                    end else if (rot_q >= rot_last) begin
                        rot_d   = '0;
                        delay_d = delay_q + DelayW'(1);
                    end else begin
                        rot_d = rot_q + RotStep;
                    end
                end
            end
            StLocked: begin
                if (rx_vld) begin
                    win_d       = win_q + WinW'(1);
                    mis_d       = mis_total;
                    sym_d       = sym_sum[CNT_W] ? '1 : sym_sum[CNT_W-1:0];
                    err_d       = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                    err_pulse_d = mismatch;
                end
                if (win_done) begin
                    win_d = '0;
                    mis_d = '0;
                    if (mis_total > WinW'(LOSS_THR)) begin
                        state_d = StSearch;
                        delay_d = '0;
                        rot_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A modulation change invalidates any rotation/delay candidate found so far.
        if (state_q != StIdle && is_bpsk != bpsk_q) begin
            state_d = StSearch;
            delay_d = '0;
            rot_d   = '0;
            win_d   = '0;
            mis_d   = '0;
        end
        if (!enable) begin
            state_d = StIdle;
            delay_d = '0;
            rot_d   = '0;
            win_d   = '0;
            mis_d   = '0;
        end
        if (clear) begin
            sym_d = '0;
            err_d = '0;
        end
    end

    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            state_q     <= StIdle;
            hist_q      <= '0;
            delay_q     <= '0;
            rot_q       <= '0;
            win_q       <= '0;
            mis_q       <= '0;
            sym_q       <= '0;
            err_q       <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            bpsk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            delay_q     <= delay_d;
            rot_q       <= rot_d;
            win_q       <= win_d;
            mis_q       <= mis_d;
            sym_q       <= sym_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= (state_d == StLocked);
            bpsk_q      <= is_bpsk;
        end
    end

    assign locked    = locked_q;
    assign delay     = delay_q;
    assign rot       = rot_q;
    assign sym_cnt   = sym_q;
    assign err_cnt   = err_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_psk_loopback_ber.sv
// Randomized self-checking bench for psk_loopback_ber with a behavioural loopback channel model.
module tb_psk_loopback_ber;

    localparam int unsigned DEPTH    = 32;
    localparam int unsigned WIN      = 64;
    localparam int unsigned LOCK_THR = 2;
    localparam int unsigned LOSS_THR = 16;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned DW       = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             is_bpsk = 1'b0;
    logic             clear = 1'b0;
    logic [1:0]       tx_bits = 2'b00;
    logic             tx_vld = 1'b0;
    logic [1:0]       rx_bits = 2'b00;
    logic             rx_vld = 1'b0;
    logic             locked;
    logic [DW-1:0]    delay;
    logic [1:0]       rot;
    logic [CNT_W-1:0] sym_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_pulse;

    psk_loopback_ber #(
        .DEPTH    (DEPTH),
        .WIN      (WIN),
        .LOCK_THR (LOCK_THR),
        .LOSS_THR (LOSS_THR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_16M384   (clk),
        .rst_n_16M384 (rst_n),
        .enable       (enable),
        .is_bpsk      (is_bpsk),
        .clear        (clear),
        .tx_bits      (tx_bits),
        .tx_vld       (tx_vld),
        .rx_bits      (rx_bits),
        .rx_vld       (rx_vld),
        .locked       (locked),
        .delay        (delay),
        .rot          (rot),
        .sym_cnt      (sym_cnt),
        .err_cnt      (err_cnt),
        .err_pulse    (err_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Channel model: txh[0] is the newest symbol sent; rx = rotate(txh[ch_delay], ch_rot).
    logic [1:0] txh [DEPTH];
    int ch_delay = 0;
    int ch_rot = 0;
    int rx_count = 0;
    int lock_mark = 0;

    function automatic logic [1:0] model_rotate(logic [1:0] s, int r, logic bpsk);
        logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        int pos = 0;
        if (bpsk) return {s[1], s[0] ^ ((r % 2) != 0)};
        for (int k = 0; k < 4; k++) if (gray[k] == s) pos = k;
        return gray[(pos + r) % 4];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) txh[k] = 2'b00;
    endtask

    task automatic step(input logic tv, input logic rv, input logic [1:0] flip, input logic clr);
        logic [1:0] s;
        logic [1:0] r;
        s = 2'($urandom);
        r = model_rotate(txh[ch_delay], ch_rot, is_bpsk) ^ flip;
        if (is_bpsk) r[1] = 1'($urandom);
        tx_bits = s;
        tx_vld  = tv;
        rx_bits = rv ? r : 2'($urandom);
        rx_vld  = rv;
        clear   = clr;
        if (tv) begin
            for (int k = DEPTH - 1; k > 0; k--) txh[k] = txh[k-1];
            txh[0] = s;
        end
        if (rv) rx_count++;
        @(posedge clk);
        #1;
        tx_vld = 1'b0;
        rx_vld = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic wait_lock(input int budget, input bit gaps, output int used);
        used = 0;
        while (locked !== 1'b1 && used < budget) begin
            logic v;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(v, v, 2'b00, 1'b0);
            used++;
        end
        lock_mark = rx_count;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({locked, delay, rot, sym_cnt, err_cnt, err_pulse} !== '0)
            $display("FAIL reset_outputs: got %b required all zero",
                     {locked, delay, rot, sym_cnt, err_cnt, err_pulse});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bpsk_lock();
        int used;
        int pulses = 0;
        is_bpsk  = 1'b1;
        enable   = 1'b1;
        ch_delay = 8;
        ch_rot   = 0;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        wait_lock(4000, 1'b0, used);
        n_checks++; if (locked !== 1'b1) $display("FAIL bpsk_lock: locked=%0b required 1", locked); else n_pass++;
        n_checks++; if (delay !== DW'(8)) $display("FAIL bpsk_delay: got %0d required 8", delay); else n_pass++;
        n_checks++; if (rot !== 2'd0) $display("FAIL bpsk_rot: got %0d required 0", rot); else n_pass++;
        step(1'b0, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b1, 2'b00, 1'b0);
            if (err_pulse === 1'b1) pulses++;
        end
        n_checks++; if (err_cnt !== 0) $display("FAIL bpsk_err_cnt: got %0d required 0", err_cnt); else n_pass++;
        n_checks++; if (sym_cnt !== 1000) $display("FAIL bpsk_sym_cnt: got %0d required 1000", sym_cnt); else n_pass++;
        n_checks++; if (pulses !== 0) $display("FAIL bpsk_pulses: got %0d required 0", pulses); else n_pass++;
    endtask

    task automatic test_bit_flips();
        int flips = 0;
        int pulses = 0;
        int bad = 0;
        logic f;
        step(1'b0, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 3 * WIN; i++) begin
            f = (i % 10) == 9;
            step(1'b1, 1'b1, {1'b0, f}, 1'b0);
            if (f) flips++;
            if (err_pulse === 1'b1) pulses++;
            if (err_pulse !== f) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL flip_pulse_timing: %0d cycles wrong, required 0", bad); else n_pass++;
        n_checks++; if (pulses !== flips) $display("FAIL flip_pulse_count: got %0d required %0d", pulses, flips); else n_pass++;
        n_checks++; if (err_cnt !== flips) $display("FAIL flip_err_cnt: got %0d required %0d", err_cnt, flips); else n_pass++;
        n_checks++; if (sym_cnt !== 3 * WIN) $display("FAIL flip_sym_cnt: got %0d required %0d", sym_cnt, 3 * WIN); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL flip_lock_kept: locked=%0b required 1", locked); else n_pass++;
    endtask

    task automatic test_delay_change();
        int used;
        while (((rx_count - lock_mark) % WIN) != 0) step(1'b1, 1'b1, 2'b00, 1'b0);
        ch_delay = 12;
        repeat (WIN - 1) step(1'b1, 1'b1, 2'b00, 1'b0);
        n_checks++; if (locked !== 1'b1) $display("FAIL loss_partial_window: locked=%0b required 1", locked); else n_pass++;
        step(1'b1, 1'b1, 2'b00, 1'b0);
        n_checks++; if (locked !== 1'b0) $display("FAIL loss_drop: locked=%0b required 0", locked); else n_pass++;
        n_checks++; if ({delay, rot} !== '0) $display("FAIL loss_restart: delay=%0d rot=%0d required 0/0", delay, rot); else n_pass++;
        wait_lock(4000, 1'b0, used);
        n_checks++; if (locked !== 1'b1) $display("FAIL relock: locked=%0b required 1", locked); else n_pass++;
        n_checks++; if (delay !== DW'(12)) $display("FAIL relock_delay: got %0d required 12", delay); else n_pass++;
        n_checks++; if (rot !== 2'd0) $display("FAIL relock_rot: got %0d required 0", rot); else n_pass++;
    endtask

    task automatic test_qpsk_rot(output int exp_sym);
        int used;
        logic v;
        is_bpsk  = 1'b0;
        ch_delay = 5;
        ch_rot   = 2;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++; if ({locked, delay, rot} !== '0) $display("FAIL mode_restart: locked=%0b delay=%0d rot=%0d required 0/0/0", locked, delay, rot); else n_pass++;
        wait_lock(6000, 1'b1, used);
        n_checks++; if (locked !== 1'b1) $display("FAIL qpsk_lock: locked=%0b required 1", locked); else n_pass++;
        n_checks++; if (delay !== DW'(5)) $display("FAIL qpsk_delay: got %0d required 5", delay); else n_pass++;
        n_checks++; if (rot !== 2'd2) $display("FAIL qpsk_rot: got %0d required 2", rot); else n_pass++;
        step(1'b0, 1'b0, 2'b00, 1'b1);
        exp_sym = 0;
        for (int i = 0; i < 300; i++) begin
            v = $urandom_range(0, 3) != 0;
            step(v, v, 2'b00, 1'b0);
            if (v) exp_sym++;
        end
        n_checks++; if (sym_cnt !== exp_sym) $display("FAIL qpsk_sym_cnt: got %0d required %0d", sym_cnt, exp_sym); else n_pass++;
        n_checks++; if (err_cnt !== 0) $display("FAIL qpsk_err_cnt: got %0d required 0", err_cnt); else n_pass++;
    endtask

    task automatic test_coincident(input int held_sym);
        int used;
        enable = 1'b0;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++; if ({locked, delay, rot} !== '0) $display("FAIL disable_idle: locked=%0b delay=%0d rot=%0d required 0/0/0", locked, delay, rot); else n_pass++;
        n_checks++; if (sym_cnt !== held_sym) $display("FAIL disable_held: got %0d required %0d", sym_cnt, held_sym); else n_pass++;
        enable   = 1'b1;
        ch_delay = 0;
        ch_rot   = 0;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        wait_lock(200, 1'b0, used);
        n_checks++; if (locked !== 1'b1 || used !== WIN) $display("FAIL coinc_lock: locked=%0b after %0d symbols, required 1 after %0d", locked, used, WIN); else n_pass++;
        n_checks++; if ({delay, rot} !== '0) $display("FAIL coinc_delay_rot: delay=%0d rot=%0d required 0/0", delay, rot); else n_pass++;
        step(1'b1, 1'b1, 2'b01, 1'b1);
        n_checks++; if ({sym_cnt, err_cnt} !== '0) $display("FAIL clear_priority: sym=%0d err=%0d required 0/0", sym_cnt, err_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int used;
        repeat (20) step(1'b1, 1'b1, 2'b00, 1'b0);
        step(1'b1, 1'b1, 2'b11, 1'b0);
        n_checks++; if (sym_cnt !== 21 || err_cnt !== 2 || err_pulse !== 1'b1) $display("FAIL pre_reset_stats: sym=%0d err=%0d pulse=%0b required 21/2/1", sym_cnt, err_cnt, err_pulse); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({locked, delay, rot, sym_cnt, err_cnt, err_pulse} !== '0) $display("FAIL reset_locked_async: got %b required all zero", {locked, delay, rot, sym_cnt, err_cnt, err_pulse}); else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++; if ({locked, delay, rot} !== '0) $display("FAIL post_reset_start: locked=%0b delay=%0d rot=%0d required 0/0/0", locked, delay, rot); else n_pass++;
        ch_delay = 3;
        ch_rot   = 1;
        repeat (100) step(1'b1, 1'b1, 2'b00, 1'b0);
        n_checks++; if (locked !== 1'b0 || delay !== DW'(0) || rot !== 2'd1) $display("FAIL mid_search: locked=%0b delay=%0d rot=%0d required 0/0/1", locked, delay, rot); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({locked, delay, rot, sym_cnt, err_cnt, err_pulse} !== '0) $display("FAIL reset_search_async: got %b required all zero", {locked, delay, rot, sym_cnt, err_cnt, err_pulse}); else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        wait_lock(3000, 1'b0, used);
        n_checks++; if (locked !== 1'b1 || delay !== DW'(3) || rot !== 2'd1) $display("FAIL post_reset_relock: locked=%0b delay=%0d rot=%0d required 1/3/1", locked, delay, rot); else n_pass++;
    endtask

    initial begin
        int held;
        test_reset();
        test_bpsk_lock();
        test_bit_flips();
        test_delay_change();
        test_qpsk_rot(held);
        test_coincident(held);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
